alu_stage: RTL and testbench
============================

ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width; only 16 is required to be supported.
REQ-002 SHALL have parameter MUL_CYCLES, default 16, multiply iteration count; it SHALL equal WIDTH.
REQ-003 SHALL have port I_clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port I_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port I_enable  input  1  stage enable; when 0, all state SHALL hold.
REQ-006 SHALL have port I_start  input  1  requests one operation.
REQ-007 SHALL have port I_aluop  input  4  operation code.
REQ-008 SHALL have port I_dataA  input  16  operand A, driven from register-file port rA.
REQ-009 SHALL have port I_dataB  input  16  operand B, driven from register-file port rB.
REQ-010 SHALL have port I_imm  input  8  immediate byte.
REQ-011 SHALL have port O_result  output  16  value for register-file rD_in.
REQ-012 SHALL have port O_write  output  1  register-file rD_write strobe.
REQ-013 SHALL have port O_write_pos  output  2  rD_write_pos: 0 = full word, 1 = low byte, 2 = high byte.
REQ-014 SHALL have port O_flags  output  4  {Z,N,C,V}.
REQ-015 SHALL have port O_busy  output  1  a multiply is in progress.
REQ-016 SHALL have port O_done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement an FSM with states IDLE, MUL, DONE; transitions SHALL occur only when I_enable=1.
REQ-018 SHALL accept I_start only in IDLE; opcodes, operands and I_imm SHALL be latched on acceptance.
REQ-019 SHALL ignore I_start in MUL and DONE, with no queuing.
REQ-020 SHALL, for single-cycle ops, go IDLE->DONE, so O_done is high in the cycle after acceptance (latency 1).
REQ-021 SHALL implement op codes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by B[3:0], 7 SHR logical A by B[3:0].
REQ-022 SHALL implement op codes: 8 LDHI ({imm,8'h00}, pos 2), 9 LDLO ({8'h00,imm}, pos 1), 10 CMP (SUB, flags only), 11 MUL, 12-15 NOP.
REQ-023 SHALL perform MUL as an iterative shift-add for MUL_CYCLES cycles in state MUL, then go to DONE (latency 17); result SHALL be the low 16 bits.
REQ-024 SHALL drive O_busy=1 exactly while in state MUL.
REQ-025 SHALL, in DONE, assert O_done=1 for one cycle and return to IDLE, during which I_start SHALL NOT be accepted.
REQ-026 SHALL drive O_write=1 only in DONE, and only for ops 0-9 and 11; for ops 10 and 12-15 it SHALL be 0.
REQ-027 SHALL drive O_write_pos=0 for all writing ops except LDHI/LDLO.
REQ-028 SHALL hold O_result and O_write_pos stable from DONE until the next DONE.
REQ-029 SHALL update O_flags only in DONE, and not for NOP.
REQ-030 SHALL compute flags as: Z = result==0; N = result[15].
REQ-031 SHALL, for ADD, set C = carry-out and V = signed overflow.
REQ-032 SHALL, for SUB/CMP, set C = borrow (A<B unsigned) and V = signed overflow.
REQ-033 SHALL, for logic, shift and load ops, clear C and V.
REQ-034 SHALL, for MUL, set C = 1 when the upper 16 product bits are nonzero, and V = 0.
REQ-035 SHALL treat a shift amount of 0 as a pass-through of A; all sums SHALL wrap modulo 2^16.
REQ-036 SHALL freeze state, counter, partial product and all outputs (including O_done) when I_enable=0 mid-multiply or in DONE; O_done SHALL remain high until the enabled cycle completes.

Reset
REQ-037 SHALL, when I_reset=1 at any time (including mid-MUL), immediately enter IDLE with: O_result=0, O_write=0, O_write_pos=0, O_flags=0, O_busy=0, O_done=0, counter=0, partial product=0.
REQ-038 SHALL require I_reset to be held for at least one I_clk edge; the first start SHALL be accepted on the first enabled edge after deassertion.

Structure
REQ-039 SHALL take opcode constants, FSM state encodings, flag bit indices and write_pos codes from shared package cpu_pkg, which the register file and decoder also use.
REQ-040 SHALL place the iterative multiplier in sub-module alu_mul (ports: clock, reset, enable, start, operands, busy, done, product).
REQ-041 SHALL keep the single-cycle datapath and the FSM in alu_stage.

Verification
REQ-042 SHALL verify: ADD 0x7FFF+0x0001 -> O_result=0x8000, flags N=1, V=1, Z=0, C=0; O_write=1, O_done one cycle after start.
REQ-043 SHALL verify: CMP 0x0003,0x0005 -> O_write=0, flags C=1, N=1, Z=0; O_result unchanged.
REQ-044 SHALL verify: MUL 0x0100*0x0100 -> O_busy high 16 cycles, O_done at cycle 17, O_result=0x0000, Z=1, C=1.
REQ-045 SHALL verify: LDHI imm=0xAB -> O_result=0xAB00, O_write_pos=2; LDLO imm=0xCD -> 0x00CD, pos 1.
REQ-046 SHALL verify: MUL 3*5 with I_enable low for 4 cycles mid-run -> O_done at cycle 21, result 0x000F; second I_start during busy ignored.
REQ-047 SHALL verify: I_reset asserted at MUL cycle 8 -> all outputs 0 immediately; a new ADD 2+2 after release -> 0x0004.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU opcodes, ALU FSM states, flag bit positions and
// register-file write-position codes, used by the ALU, decoder and register file.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_LDHI = 4'd8;
  localparam logic [3:0] OP_LDLO = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // Flags are packed {Z,N,C,V}.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] WPOS_WORD = 2'd0;
  localparam logic [1:0] WPOS_LO   = 2'd1;
  localparam logic [1:0] WPOS_HI   = 2'd2;

  // Ops that write rD: everything up to LDLO, plus MUL.
  function automatic logic op_writes(input logic [3:0] op);
    return (op <= OP_LDLO) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_mul.sv
// Iterative shift-add multiplier: one partial-product step per enabled cycle.
// O_done and O_product are combinational so the caller can capture on the last step.
module alu_mul #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic               I_enable,
  input  logic               I_start,
  input  logic [WIDTH-1:0]   I_a,
  input  logic [WIDTH-1:0]   I_b,
  output logic               O_busy,
  output logic               O_done,
  output logic [2*WIDTH-1:0] O_product
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [CNT_W-1:0]   cnt_q;

  always_comb begin
    prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign O_busy    = (cnt_q != '0);
  assign O_done    = O_busy && (cnt_q == CNT_W'(1));
  assign O_product = prod_d;

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (I_enable) begin
      if (I_start && !O_busy) begin
        mcand_q  <= {{WIDTH{1'b0}}, I_a};
        mplier_q <= I_b;
        prod_q   <= '0;
        cnt_q    <= CNT_W'(MUL_CYCLES);
      end else if (O_busy) begin
        prod_q   <= prod_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_stage.sv
// ALU pipeline stage: single-cycle datapath plus IDLE/MUL/DONE control FSM.
// Single-cycle results are computed from the inputs on acceptance and registered.
module alu_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic             I_enable,
  input  logic             I_start,
  input  logic [3:0]       I_aluop,
  input  logic [WIDTH-1:0] I_dataA,
  input  logic [WIDTH-1:0] I_dataB,
  input  logic [7:0]       I_imm,
  output logic [WIDTH-1:0] O_result,
  output logic             O_write,
  output logic [1:0]       O_write_pos,
  output logic [3:0]       O_flags,
  output logic             O_busy,
  output logic             O_done
);

  alu_state_t       state_q;
  logic [WIDTH-1:0] result_q;
  logic             write_q;
  logic [1:0]       wpos_q;
  logic [3:0]       flags_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0]   res_d;
  logic [1:0]         wpos_d;
  logic [3:0]         flags_d;
  logic [3:0]         mflags_d;
  logic [WIDTH:0]     sum;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = I_start && (state_q == ST_IDLE) && (I_aluop == OP_MUL);

  alu_mul #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .I_clk     (I_clk),
    .I_reset   (I_reset),
    .I_enable  (I_enable),
    .I_start   (mul_start),
    .I_a       (I_dataA),
    .I_b       (I_dataB),
    .O_busy    (mul_busy),
    .O_done    (mul_done),
    .O_product (mul_prod)
  );

  always_comb begin
    res_d   = '0;
    wpos_d  = WPOS_WORD;
    flags_d = '0;
    sum     = '0;
    case (I_aluop)
      OP_ADD: begin
        sum              = {1'b0, I_dataA} + {1'b0, I_dataB};
        res_d            = sum[WIDTH-1:0];
        flags_d[FLAG_C]  = sum[WIDTH];
        flags_d[FLAG_V]  = (I_dataA[WIDTH-1] == I_dataB[WIDTH-1]) &&
                           (res_d[WIDTH-1] != I_dataA[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        // The extra MSB of the difference is the unsigned borrow.
        sum              = {1'b0, I_dataA} - {1'b0, I_dataB};
        res_d            = sum[WIDTH-1:0];
        flags_d[FLAG_C]  = sum[WIDTH];
        flags_d[FLAG_V]  = (I_dataA[WIDTH-1] != I_dataB[WIDTH-1]) &&
                           (res_d[WIDTH-1] != I_dataA[WIDTH-1]);
      end
      OP_AND:  res_d = I_dataA & I_dataB;
      OP_OR:   res_d = I_dataA | I_dataB;
      OP_XOR:  res_d = I_dataA ^ I_dataB;
      OP_NOT:  res_d = ~I_dataA;
      OP_SHL:  res_d = I_dataA << I_dataB[3:0];
      OP_SHR:  res_d = I_dataA >> I_dataB[3:0];
      OP_LDHI: begin
        res_d  = {I_imm, 8'h00};
        wpos_d = WPOS_HI;
      end
      OP_LDLO: begin
        res_d  = {8'h00, I_imm};
        wpos_d = WPOS_LO;
      end
      default: ;
    endcase
    flags_d[FLAG_Z] = (res_d == '0);
    flags_d[FLAG_N] = res_d[WIDTH-1];

    mflags_d         = '0;
    mflags_d[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
    mflags_d[FLAG_N] = mul_prod[WIDTH-1];
    mflags_d[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      write_q  <= 1'b0;
      wpos_q   <= WPOS_WORD;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (I_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (I_start) begin
            if (I_aluop == OP_MUL) begin
              state_q <= ST_MUL;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              write_q <= op_writes(I_aluop);
              if (op_writes(I_aluop)) begin
                result_q <= res_d;
                wpos_q   <= wpos_d;
              end
              if (I_aluop <= OP_MUL) flags_q <= flags_d;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            write_q  <= 1'b1;
            result_q <= mul_prod[WIDTH-1:0];
            wpos_q   <= WPOS_WORD;
            flags_q  <= mflags_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          write_q <= 1'b0;
        end
      endcase
    end
  end

  assign O_result    = result_q;
  assign O_write     = write_q;
  assign O_write_pos = wpos_q;
  assign O_flags     = flags_q;
  assign O_busy      = busy_q;
  assign O_done      = done_q;

endmodule

// File: tb/tb_alu_stage.sv
// Directed-vector bench for alu_stage; expected values are hand-computed.
module tb_alu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [7:0]  imm;
  logic [15:0] result;
  logic        write;
  logic [1:0]  wpos;
  logic [3:0]  flags;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  alu_stage #(.WIDTH(16), .MUL_CYCLES(16)) dut (
    .I_clk       (clk),
    .I_reset     (rst),
    .I_enable    (en),
    .I_start     (start),
    .I_aluop     (op),
    .I_dataA     (a),
    .I_dataB     (b),
    .I_imm       (imm),
    .O_result    (result),
    .O_write     (write),
    .O_write_pos (wpos),
    .O_flags     (flags),
    .O_busy      (busy),
    .O_done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse over a single edge.
  task automatic issue(input logic [3:0] o, input logic [15:0] va, input logic [15:0] vb,
                       input logic [7:0] vi);
    op = o; a = va; b = vb; imm = vi; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0; imm = '0;
    #1;
    checks++; if ({result, write, wpos, flags, busy, done} !== 25'd0) begin errors++;
      $display("FAIL reset_async: outputs=%h expected 0", {result, write, wpos, flags, busy, done}); end
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if ({result, write, wpos, flags, busy, done} !== 25'd0) begin errors++;
      $display("FAIL reset_release: outputs=%h expected 0", {result, write, wpos, flags, busy, done}); end
  endtask

  task automatic test_add();
    op = 4'd0; a = 16'h7FFF; b = 16'h0001; start = 1'b1;
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL add_pre_done: done=%b expected 0", done); end
    step(); start = 1'b0;
    checks++; if (done !== 1'b1 || write !== 1'b1) begin errors++;
      $display("FAIL add_strobe: done=%b write=%b expected 1 1", done, write); end
    checks++; if (result !== 16'h8000) begin errors++;
      $display("FAIL add_result: got %h expected 8000", result); end
    checks++; if (flags !== 4'b0101 || wpos !== 2'd0) begin errors++;
      $display("FAIL add_flags: flags=%b pos=%0d expected 0101 0", flags, wpos); end
    step();
    checks++; if (done !== 1'b0 || write !== 1'b0 || result !== 16'h8000) begin errors++;
      $display("FAIL add_after: done=%b write=%b result=%h expected 0 0 8000", done, write, result); end
  endtask

  task automatic test_cmp();
    issue(4'd10, 16'h0003, 16'h0005, 8'h00);
    checks++; if (done !== 1'b1 || write !== 1'b0) begin errors++;
      $display("FAIL cmp_strobe: done=%b write=%b expected 1 0", done, write); end
    checks++; if (flags !== 4'b0110 || result !== 16'h8000) begin errors++;
      $display("FAIL cmp_flags: flags=%b result=%h expected 0110 8000", flags, result); end
    step();
  endtask

  task automatic test_loads();
    issue(4'd8, 16'h1111, 16'h2222, 8'hAB);
    checks++; if (result !== 16'hAB00 || wpos !== 2'd2 || write !== 1'b1 || flags !== 4'b0100) begin errors++;
      $display("FAIL ldhi: result=%h pos=%0d write=%b flags=%b expected AB00 2 1 0100", result, wpos, write, flags); end
    step();
    issue(4'd9, 16'h1111, 16'h2222, 8'hCD);
    checks++; if (result !== 16'h00CD || wpos !== 2'd1 || flags !== 4'b0000) begin errors++;
      $display("FAIL ldlo: result=%h pos=%0d flags=%b expected 00CD 1 0000", result, wpos, flags); end
    step();
  endtask

  task automatic test_alu_ops();
    logic [3:0]  vop [8]  = '{4'd1, 4'd0, 4'd6, 4'd7, 4'd6, 4'd4, 4'd5, 4'd2};
    logic [15:0] va  [8]  = '{16'h8000, 16'hFFFF, 16'h0001, 16'h8000, 16'h1234, 16'hF0F0, 16'h00FF, 16'hF0F0};
    logic [15:0] vb  [8]  = '{16'h0001, 16'h0001, 16'h0004, 16'h000F, 16'hFFF0, 16'h0FF0, 16'h0000, 16'h0FF0};
    logic [15:0] xres[8]  = '{16'h7FFF, 16'h0000, 16'h0010, 16'h0001, 16'h1234, 16'hFF00, 16'hFF00, 16'h00F0};
    logic [3:0]  xflg[8]  = '{4'b0001, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      issue(vop[i], va[i], vb[i], 8'h00);
      checks++; if (result !== xres[i] || flags !== xflg[i] || wpos !== 2'd0) begin errors++;
        $display("FAIL alu_vec%0d: result=%h flags=%b pos=%0d expected %h %b 0", i, result, flags, wpos, xres[i], xflg[i]); end
      step();
    end
  endtask

  task automatic test_nop();
    issue(4'd13, 16'h1234, 16'h5678, 8'h99);
    checks++; if (done !== 1'b1 || write !== 1'b0 || result !== 16'h00F0 || flags !== 4'b0000) begin errors++;
      $display("FAIL nop: done=%b write=%b result=%h flags=%b expected 1 0 00F0 0000", done, write, result, flags); end
    step();
  endtask

  task automatic test_done_freeze();
    issue(4'd3, 16'h0F00, 16'h00F0, 8'h00);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (done !== 1'b1 || result !== 16'h0FF0) begin errors++;
        $display("FAIL done_freeze%0d: done=%b result=%h expected 1 0FF0", i, done, result); end
    end
    en = 1'b1;
    step();
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL done_release: done=%b expected 0", done); end
  endtask

  task automatic test_mul_wrap();
    int busy_cnt = 0;
    int done_at  = 0;
    logic wr_at_done = 1'b0;
    op = 4'd11; a = 16'h0100; b = 16'h0100; start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done && done_at == 0) begin done_at = i; wr_at_done = write; end
    end
    checks++; if (busy_cnt !== 16) begin errors++;
      $display("FAIL mul_busy_len: got %0d cycles expected 16", busy_cnt); end
    checks++; if (done_at !== 17 || wr_at_done !== 1'b1) begin errors++;
      $display("FAIL mul_latency: done at %0d write=%b expected 17 1", done_at, wr_at_done); end
    checks++; if (result !== 16'h0000 || flags !== 4'b1010) begin errors++;
      $display("FAIL mul_wrap: result=%h flags=%b expected 0000 1010", result, flags); end
  endtask

  task automatic test_mul_stall();
    int done_at  = 0;
    int done_cnt = 0;
    int busy_lo  = 0;
    for (int i = 1; i <= 40; i++) begin
      start = (i == 1) || (i == 5);
      op    = (i == 1) ? 4'd11 : 4'd0;
      a     = (i == 1) ? 16'h0003 : 16'h0009;
      b     = (i == 1) ? 16'h0005 : 16'h0009;
      en    = !(i >= 8 && i <= 11);
      step();
      if (i >= 8 && i <= 11 && !busy) busy_lo++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
    end
    start = 1'b0; en = 1'b1;
    checks++; if (done_at !== 21 || done_cnt !== 1) begin errors++;
      $display("FAIL mul_stall_latency: done at %0d count %0d expected 21 1", done_at, done_cnt); end
    checks++; if (busy_lo !== 0) begin errors++;
      $display("FAIL mul_stall_busy: busy dropped %0d cycles while disabled expected 0", busy_lo); end
    checks++; if (result !== 16'h000F || flags !== 4'b0000) begin errors++;
      $display("FAIL mul_stall_result: result=%h flags=%b expected 000F 0000", result, flags); end
  endtask

  task automatic test_reset_mid_mul();
    issue(4'd11, 16'h1234, 16'h0002, 8'h00);
    for (int i = 2; i <= 8; i++) step();
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL rst_pre_busy: busy=%b expected 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({result, write, wpos, flags, busy, done} !== 25'd0) begin errors++;
      $display("FAIL rst_mid_mul: outputs=%h expected 0", {result, write, wpos, flags, busy, done}); end
    step();
    rst = 1'b0;
    issue(4'd0, 16'h0002, 16'h0002, 8'h00);
    checks++; if (done !== 1'b1 || result !== 16'h0004 || flags !== 4'b0000) begin errors++;
      $display("FAIL rst_then_add: done=%b result=%h flags=%b expected 1 0004 0000", done, result, flags); end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
        $display("FAIL rst_stale_mul%0d: done=%b busy=%b expected 0 0", i, done, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_loads();
    test_alu_ops();
    test_nop();
    test_done_freeze();
    test_mul_wrap();
    test_mul_stall();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
